// File: rtl/mem_arbiter.sv
// mem_arbiter: round-robin arbiter of an instruction-fetch port and a data port onto one memory port
module mem_arbiter #(
    parameter int          TIMEOUT  = 16,
    parameter logic [31:0] ERR_WORD = 32'hDEADBEEF
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        i_req,
    input  logic [31:0] i_addr,
    output logic [31:0] i_rdata,
    output logic        i_ready,
    output logic        i_err,
    input  logic        d_req,
    input  logic        d_we,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    input  logic [3:0]  d_be,
    output logic [31:0] d_rdata,
    output logic        d_ready,
    output logic        d_err,
    output logic        m_req,
    output logic        m_we,
    output logic [31:0] m_addr,
    output logic [31:0] m_wdata,
    output logic [3:0]  m_be,
    input  logic [31:0] m_rdata,
    input  logic        m_ack,
    output logic [1:0]  owner
);
    typedef enum logic [1:0] {IDLE, GRANT_I, GRANT_D, RESP} state_t;
    state_t      state, state_nx;
    logic        last_d;
    logic [7:0]  cnt;
    logic        busy, tout, done, pick_i, pick_d;
    // arbitration, timeout detection and next state; ack in the final wait cycle wins over abort
    always_comb begin
        busy     = (state == GRANT_I) || (state == GRANT_D);
        tout     = busy && !m_ack && (cnt == 8'(TIMEOUT - 1));
        done     = busy && (m_ack || tout);
        pick_i   = (state == IDLE) && i_req && (!d_req || last_d);
        pick_d   = (state == IDLE) && d_req && !pick_i;
        state_nx = pick_i ? GRANT_I : pick_d ? GRANT_D : done ? RESP : (state == RESP) ? IDLE : state;
    end
    // state register
    always_ff @(posedge clock or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nx;
    end
    // command latch at grant, wait counting, and result capture into the one-cycle response
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            m_req   <= 1'b0;
            m_we    <= 1'b0;
            m_addr  <= '0;
            m_wdata <= '0;
            m_be    <= '0;
            cnt     <= '0;
            last_d  <= 1'b1;
            owner   <= 2'b00;
            i_ready <= 1'b0;
            i_err   <= 1'b0;
            i_rdata <= '0;
            d_ready <= 1'b0;
            d_err   <= 1'b0;
            d_rdata <= '0;
        end else begin
            i_ready <= 1'b0;
            i_err   <= 1'b0;
            d_ready <= 1'b0;
            d_err   <= 1'b0;
            if (pick_i) begin
                m_req   <= 1'b1;
                m_we    <= 1'b0;
                m_addr  <= i_addr;
                m_wdata <= '0;
                m_be    <= 4'hF;
                cnt     <= '0;
                last_d  <= 1'b0;
                owner   <= 2'b01;
            end else if (pick_d) begin
                m_req   <= 1'b1;
                m_we    <= d_we;
                m_addr  <= d_addr;
                m_wdata <= d_wdata;
                m_be    <= d_be;
                cnt     <= '0;
                last_d  <= 1'b1;
                owner   <= 2'b10;
            end else if (done) begin
                m_req <= 1'b0;
                if (state == GRANT_I) begin
                    i_ready <= 1'b1;
                    i_err   <= tout;
                    i_rdata <= tout ? ERR_WORD : m_rdata;
                end else begin
                    d_ready <= 1'b1;
                    d_err   <= tout;
                    if (!m_we) d_rdata <= tout ? ERR_WORD : m_rdata;
                end
            end else if (busy) begin
                cnt <= cnt + 8'd1;
            end else if (state == RESP) begin
                owner <= 2'b00;
            end
        end
    end
endmodule
